// File: rtl/hdmi_pkg.sv
// Shared HDMI TMDS constants: period encodings, control/guard codes, TERC4 table,
// and the stage-1 payload carried between q_m generation and DC balancing.
package hdmi_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned QM_W   = 9;
  localparam int unsigned SYM_W  = 10;
  localparam int unsigned BIAS_W = 5;

  typedef enum logic [2:0] {
    MODE_CTRL   = 3'd0,
    MODE_VIDEO  = 3'd1,
    MODE_VGUARD = 3'd2,
    MODE_ISLAND = 3'd3,
    MODE_DGUARD = 3'd4
  } tmds_mode_e;

  // Indexed by {C1,C0}
  localparam logic [SYM_W-1:0] CTRL_CODE [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  localparam logic [SYM_W-1:0] VGUARD_CH02 = 10'b1011001100;
  localparam logic [SYM_W-1:0] VGUARD_CH1  = 10'b0100110011;
  localparam logic [SYM_W-1:0] DGUARD_CH12 = 10'b0100110011;

  localparam logic [SYM_W-1:0] TERC4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  typedef struct packed {
    logic             video;
    logic [QM_W-1:0]  qm;
    logic [SYM_W-1:0] sym;
  } tmds_stage_t;

endpackage

// File: rtl/tmds_qm_encode.sv
// Transition-minimising stage: XOR or XNOR chain over the pixel byte, bit 8 flags XOR.
module tmds_qm_encode
  import hdmi_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  output logic [QM_W-1:0]   o_q_m_c
);

  logic [3:0] ones;
  logic       use_xnor;
  logic       acc;

  always_comb begin
    ones = '0;
    for (int i = 0; i < int'(DATA_W); i++) ones = ones + 4'(i_data[i]);
    use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !i_data[0]);
    acc = i_data[0];
    o_q_m_c = '0;
    o_q_m_c[0] = acc;
    for (int i = 1; i < int'(DATA_W); i++) begin
      acc = use_xnor ? ~(acc ^ i_data[i]) : (acc ^ i_data[i]);
      o_q_m_c[i] = acc;
    end
    o_q_m_c[QM_W-1] = ~use_xnor;
  end

endmodule

// File: rtl/tmds_encoder_hdmi.sv
// HDMI TMDS lane encoder: control, video (DVI DC-balanced), guard bands and TERC4,
// with one or two register stages from input to o_tmds.
module tmds_encoder_hdmi
  import hdmi_pkg::*;
#(
  parameter int unsigned CHANNEL = 0,
  parameter int unsigned PIPE    = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [2:0]               i_mode,
  input  logic [DATA_W-1:0]        i_data,
  input  logic [1:0]               i_ctrl,
  input  logic [3:0]               i_aux,
  output logic [SYM_W-1:0]         o_tmds,
  output logic signed [BIAS_W-1:0] o_bias
);

  localparam tmds_stage_t STAGE_FLUSH = '{video: 1'b0, qm: '0, sym: CTRL_CODE[0]};

  logic [QM_W-1:0] qm_c;
  tmds_stage_t     s1_c;
  tmds_stage_t     s1;

  tmds_qm_encode u_qm (
    .i_data  (i_data),
    .o_q_m_c (qm_c)
  );

  // Stage 1: q_m plus the fixed symbol for every non-video period
  always_comb begin
    s1_c.video = 1'b0;
    s1_c.qm    = qm_c;
    s1_c.sym   = CTRL_CODE[i_ctrl];
    case (i_mode)
      MODE_VIDEO:  s1_c.video = 1'b1;
      MODE_VGUARD: s1_c.sym   = (CHANNEL == 1) ? VGUARD_CH1 : VGUARD_CH02;
      MODE_ISLAND: s1_c.sym   = TERC4[i_aux];
      MODE_DGUARD: s1_c.sym   = (CHANNEL == 0) ? TERC4[i_aux] : DGUARD_CH12;
      default:     ;
    endcase
  end

  if (PIPE == 2) begin : g_pipe2
    always_ff @(posedge i_clk) begin
      if (i_rst) s1 <= STAGE_FLUSH;
      else       s1 <= s1_c;
    end
  end else begin : g_pipe1
    assign s1 = s1_c;
  end

  logic                q8;
  logic [3:0]          ones;
  logic signed [5:0]   balance;
  logic signed [5:0]   bias_ext;
  logic signed [5:0]   bias_nx;
  logic [SYM_W-1:0]    sym_c;

  // Stage 2: DC balancing against the bias left by the previous output symbol
  always_comb begin
    q8 = s1.qm[QM_W-1];
    ones = '0;
    for (int i = 0; i < int'(DATA_W); i++) ones = ones + 4'(s1.qm[i]);
    balance  = $signed({1'b0, ones, 1'b0}) - 6'sd8;
    bias_ext = {o_bias[BIAS_W-1], o_bias};
    sym_c    = s1.sym;
    bias_nx  = '0;
    if (s1.video) begin
      if ((bias_ext == 6'sd0) || (balance == 6'sd0)) begin
        sym_c   = {~q8, q8, q8 ? s1.qm[7:0] : ~s1.qm[7:0]};
        bias_nx = q8 ? (bias_ext + balance) : (bias_ext - balance);
      end else if (bias_ext[5] == balance[5]) begin
        sym_c   = {1'b1, q8, ~s1.qm[7:0]};
        bias_nx = bias_ext + (q8 ? 6'sd2 : 6'sd0) - balance;
      end else begin
        sym_c   = {1'b0, q8, s1.qm[7:0]};
        bias_nx = bias_ext + balance - (q8 ? 6'sd0 : 6'sd2);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_tmds <= CTRL_CODE[0];
      o_bias <= '0;
    end else begin
      o_tmds <= sym_c;
      o_bias <= $signed(bias_nx[BIAS_W-1:0]);
    end
  end

endmodule
